// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised elastic pipeline stage register
// Main entry M drives the outputs; optional skid entry S absorbs one beat of backpressure.
module pipe_stage_reg #(
  parameter int                CTRL_W      = 12,
  parameter int                DATA_W      = 128,
  parameter int                SKID        = 1,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              STALL,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [1:0]        OCCUPANCY,
  input  logic              CNT_CLR,
  output logic [CNT_W-1:0]  STARVE_CNT
);

  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic [CNT_W-1:0]  starve_cnt;
  logic              in_xfer;
  logic              out_xfer;

  // With a skid entry, ready depends only on registered state, cutting the OUT_READY path.
  always_comb begin
    IN_READY = 1'b0;
    if (SKID != 0) begin
      IN_READY = RESET_N & ~s_valid & ~STALL & ~FLUSH;
    end else begin
      IN_READY = RESET_N & (~m_valid | OUT_READY) & ~STALL & ~FLUSH;
    end
  end

  assign OUT_VALID  = m_valid & ~FLUSH;
  assign OUT_CTRL   = m_ctrl;
  assign OUT_DATA   = m_data;
  assign OCCUPANCY  = 2'(m_valid) + 2'(s_valid);
  assign STARVE_CNT = starve_cnt;
  assign in_xfer    = IN_VALID & IN_READY;
  assign out_xfer   = OUT_VALID & OUT_READY;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_valid <= 1'b0;
      m_ctrl  <= CTRL_BUBBLE;
      m_data  <= '0;
      s_valid <= 1'b0;
      s_ctrl  <= CTRL_BUBBLE;
      s_data  <= '0;
    end else if (FLUSH) begin
      m_valid <= 1'b0;
      m_ctrl  <= CTRL_BUBBLE;
      s_valid <= 1'b0;
      s_ctrl  <= CTRL_BUBBLE;
    end else if (!m_valid) begin
      if (in_xfer) begin
        m_valid <= 1'b1;
        m_ctrl  <= IN_CTRL;
        m_data  <= IN_DATA;
      end
    end else if (out_xfer) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_ctrl  <= s_ctrl;
        m_data  <= s_data;
        s_valid <= 1'b0;
        s_ctrl  <= CTRL_BUBBLE;
      end else if (in_xfer) begin
        m_valid <= 1'b1;
        m_ctrl  <= IN_CTRL;
        m_data  <= IN_DATA;
      end else begin
        // Drained with nothing behind: leave a bubble, data is don't-care and held.
        m_valid <= 1'b0;
        m_ctrl  <= CTRL_BUBBLE;
      end
    end else if (in_xfer && (SKID != 0)) begin
      s_valid <= 1'b1;
      s_ctrl  <= IN_CTRL;
      s_data  <= IN_DATA;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      starve_cnt <= '0;
    end else if (CNT_CLR) begin
      starve_cnt <= '0;
    end else if (OUT_READY && !OUT_VALID && (starve_cnt != {CNT_W{1'b1}})) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg (skid and no-skid builds)
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, stall, flush, out_valid, out_ready, cnt_clr;
  logic [11:0]  in_ctrl, out_ctrl;
  logic [127:0] in_data, out_data;
  logic [1:0]   occ;
  logic [3:0]   starve;

  logic         n_in_valid, n_in_ready, n_stall, n_flush, n_out_valid, n_out_ready, n_cnt_clr;
  logic [11:0]  n_in_ctrl, n_out_ctrl;
  logic [127:0] n_in_data, n_out_data;
  logic [1:0]   n_occ;
  logic [3:0]   n_starve;

  int tests = 0;
  int fails = 0;
  int n_pop = 0;
  int n_occ_max = 0;
  int w;
  logic [139:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(12), .DATA_W(128), .SKID(1), .CTRL_BUBBLE(12'h000), .CNT_W(4)) u_skid (
    .CLOCK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_CTRL(in_ctrl), .IN_DATA(in_data), .STALL(stall), .FLUSH(flush),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_CTRL(out_ctrl), .OUT_DATA(out_data),
    .OCCUPANCY(occ), .CNT_CLR(cnt_clr), .STARVE_CNT(starve)
  );

  pipe_stage_reg #(.CTRL_W(12), .DATA_W(128), .SKID(0), .CTRL_BUBBLE(12'h000), .CNT_W(4)) u_noskid (
    .CLOCK(clk), .RESET_N(rst_n), .IN_VALID(n_in_valid), .IN_READY(n_in_ready),
    .IN_CTRL(n_in_ctrl), .IN_DATA(n_in_data), .STALL(n_stall), .FLUSH(n_flush),
    .OUT_VALID(n_out_valid), .OUT_READY(n_out_ready), .OUT_CTRL(n_out_ctrl), .OUT_DATA(n_out_data),
    .OCCUPANCY(n_occ), .CNT_CLR(n_cnt_clr), .STARVE_CNT(n_starve)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Holds the beat until accepted; leaves IN_VALID asserted so beats can stream back-to-back.
  task automatic send(input logic [11:0] c, input logic [127:0] d, output int waited);
    logic ok = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    while (!ok && waited < 50) begin
      @(negedge clk);
      ok = in_ready;
      waited++;
      @(posedge clk);
      #1;
    end
    if (ok) exp_q.push_back({c, d});
    else begin
      tests++;
      fails++;
      $display("FAIL send_timeout: beat %0h never accepted", c);
    end
  endtask

  // Scoreboard monitor plus bubble invariant and no-skid occupancy tracking.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got beat %0h expected none", out_ctrl);
        end else begin
          logic [139:0] e;
          e = exp_q.pop_front();
          n_pop++;
          chk("sb_ctrl", 128'(out_ctrl), 128'(e[139:128]));
          chk("sb_data", out_data, e[127:0]);
        end
      end
      if (!out_valid && !flush) chk("bubble_inv", 128'(out_ctrl), 128'h0);
      if (int'(n_occ) > n_occ_max) n_occ_max = int'(n_occ);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    n_in_valid = 1'b0; n_in_ctrl = '0; n_in_data = '0;
    n_stall = 1'b0; n_flush = 1'b0; n_out_ready = 1'b0; n_cnt_clr = 1'b0;

    nxt(); neg();
    chk("rst_out_valid", 128'(out_valid), 128'h0);
    chk("rst_out_ctrl", 128'(out_ctrl), 128'h0);
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_occ", 128'(occ), 128'h0);
    chk("rst_in_ready", 128'(in_ready), 128'h0);
    chk("rst_starve", 128'(starve), 128'h0);
    nxt(); rst_n = 1'b1;
    neg();
    chk("rel_in_ready", 128'(in_ready), 128'h1);

    // Streaming with downstream always ready
    nxt(); out_ready = 1'b1; cnt_clr = 1'b1;
    nxt(); cnt_clr = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send(12'(i), 128'(i), w);
      chk("stream_wait", 128'(w), 128'h1);
    end
    in_valid = 1'b0;
    neg();
    chk("stream_last_valid", 128'(out_valid), 128'h1);
    chk("stream_last_ctrl", 128'(out_ctrl), 128'h8);
    chk("stream_last_data", out_data, 128'h8);
    chk("stream_occ", 128'(occ), 128'h1);
    chk("stream_starve", 128'(starve), 128'h1);
    nxt(); neg();
    chk("stream_empty_occ", 128'(occ), 128'h0);

    // Backpressure fills M then S
    nxt(); out_ready = 1'b0;
    send(12'h0A1, 128'h0A1, w);
    send(12'h0A2, 128'h0A2, w);
    in_ctrl = 12'h0A3; in_data = 128'h0A3;
    neg();
    chk("bp_occ", 128'(occ), 128'h2);
    chk("bp_in_ready", 128'(in_ready), 128'h0);
    chk("bp_head", 128'(out_ctrl), 128'h0A1);
    nxt(); neg();
    chk("bp_stable_ctrl", 128'(out_ctrl), 128'h0A1);
    chk("bp_stable_data", out_data, 128'h0A1);
    nxt(); out_ready = 1'b1;
    send(12'h0A3, 128'h0A3, w);
    chk("bp_a3_wait", 128'(w), 128'h2);
    in_valid = 1'b0;
    neg();
    chk("bp_a3_head", 128'(out_ctrl), 128'h0A3);
    chk("bp_a3_occ", 128'(occ), 128'h1);
    nxt();

    // Flush with both entries full and an input pending
    out_ready = 1'b0;
    send(12'h0B1, 128'h0B1, w);
    send(12'h0B2, 128'h0B2, w);
    in_ctrl = 12'h0B3; in_data = 128'h0B3;
    flush = 1'b1;
    neg();
    chk("fl_out_valid", 128'(out_valid), 128'h0);
    chk("fl_in_ready", 128'(in_ready), 128'h0);
    chk("fl_killed_ctrl", 128'(out_ctrl), 128'h0B1);
    exp_q.delete();
    nxt(); flush = 1'b0;
    neg();
    chk("fl_occ", 128'(occ), 128'h0);
    chk("fl_ctrl", 128'(out_ctrl), 128'h0);
    chk("fl_in_ready_after", 128'(in_ready), 128'h1);
    nxt(); exp_q.push_back({12'h0B3, 128'h0B3}); in_valid = 1'b0;
    neg();
    chk("fl_b3_valid", 128'(out_valid), 128'h1);
    chk("fl_b3_ctrl", 128'(out_ctrl), 128'h0B3);
    nxt(); out_ready = 1'b1;
    nxt();

    // Stall drains the held beat, then bubbles
    out_ready = 1'b0;
    send(12'h055, 128'h055, w);
    in_ctrl = 12'h066; in_data = 128'h066;
    stall = 1'b1; out_ready = 1'b1; cnt_clr = 1'b1;
    neg();
    chk("st_c1_valid", 128'(out_valid), 128'h1);
    chk("st_c1_ctrl", 128'(out_ctrl), 128'h055);
    chk("st_c1_in_ready", 128'(in_ready), 128'h0);
    nxt(); cnt_clr = 1'b0;
    neg();
    chk("st_c2_valid", 128'(out_valid), 128'h0);
    chk("st_c2_in_ready", 128'(in_ready), 128'h0);
    chk("st_c2_starve", 128'(starve), 128'h0);
    nxt(); neg();
    chk("st_c3_in_ready", 128'(in_ready), 128'h0);
    chk("st_c3_starve", 128'(starve), 128'h1);
    nxt(); stall = 1'b0; in_valid = 1'b0;
    neg();
    chk("st_starve_plus2", 128'(starve), 128'h2);
    chk("st_occ", 128'(occ), 128'h0);

    // Starvation counter saturation and clear
    nxt(); cnt_clr = 1'b1;
    nxt(); cnt_clr = 1'b0;
    repeat (20) nxt();
    neg();
    chk("sat_starve", 128'(starve), 128'hF);
    nxt(); cnt_clr = 1'b1;
    nxt(); cnt_clr = 1'b0;
    neg();
    chk("clr_starve", 128'(starve), 128'h0);

    // Asynchronous reset mid-cycle with both entries full
    nxt(); out_ready = 1'b0;
    send(12'h0C1, 128'h0C1, w);
    send(12'h0C2, 128'h0C2, w);
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("arst_pre_occ", 128'(occ), 128'h2);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'h0);
    chk("arst_out_ctrl", 128'(out_ctrl), 128'h0);
    chk("arst_out_data", out_data, 128'h0);
    chk("arst_occ", 128'(occ), 128'h0);
    chk("arst_in_ready", 128'(in_ready), 128'h0);
    chk("arst_starve", 128'(starve), 128'h0);
    exp_q.delete();
    nxt(); rst_n = 1'b1;
    neg();
    chk("arst_rel_in_ready", 128'(in_ready), 128'h1);

    // Single-register build: ready follows OUT_READY combinationally
    nxt(); n_in_valid = 1'b1; n_in_ctrl = 12'h0A1; n_in_data = 128'h0A1;
    neg();
    chk("ns_ready_empty", 128'(n_in_ready), 128'h1);
    nxt(); n_in_ctrl = 12'h0A2; n_in_data = 128'h0A2;
    neg();
    chk("ns_ready_full", 128'(n_in_ready), 128'h0);
    chk("ns_occ1", 128'(n_occ), 128'h1);
    chk("ns_head_a1", 128'(n_out_ctrl), 128'h0A1);
    n_out_ready = 1'b1;
    #1;
    chk("ns_ready_comb_up", 128'(n_in_ready), 128'h1);
    nxt(); n_in_ctrl = 12'h0A3; n_in_data = 128'h0A3;
    neg();
    chk("ns_head_a2", 128'(n_out_ctrl), 128'h0A2);
    chk("ns_ready_stream", 128'(n_in_ready), 128'h1);
    nxt(); n_in_valid = 1'b0;
    neg();
    chk("ns_head_a3", 128'(n_out_ctrl), 128'h0A3);
    chk("ns_data_a3", n_out_data, 128'h0A3);
    n_out_ready = 1'b0;
    #1;
    chk("ns_ready_comb_down", 128'(n_in_ready), 128'h0);
    nxt(); n_out_ready = 1'b1;
    nxt(); neg();
    chk("ns_drained_valid", 128'(n_out_valid), 128'h0);
    chk("ns_drained_occ", 128'(n_occ), 128'h0);
    chk("ns_starve", 128'(n_starve), 128'h0);
    chk("ns_occ_max", 128'(n_occ_max), 128'h1);

    chk("sb_drained", 128'(exp_q.size()), 128'h0);
    chk("sb_pop_count", 128'(n_pop), 128'd13);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
